// File: rtl/bound_flasher_monitor.sv
// bound_flasher_monitor: passive checker that decodes a thermometer LED bar and follows
// the bound flasher phase sequence, reporting steps, kickbacks, cycles and violations.
module bound_flasher_monitor #(
   parameter int WIDTH = 16,
   parameter int B_TOP = 16,
   parameter int B_MID = 6,
   parameter int B_UP2 = 11,
   parameter int B_LOW = 1,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] led,
   input  logic             flick,
   output logic [4:0]       level,
   output logic [2:0]       phase,
   output logic             step_up,
   output logic             step_down,
   output logic             kickback,
   output logic             cycle_done,
   output logic [CNT_W-1:0] cycle_count,
   output logic             err_pulse,
   output logic [2:0]       err_flags
);
   localparam logic [2:0] IDLE = 3'd0, UP1 = 3'd1, DN1 = 3'd2, UP2 = 3'd3,
                          DN2 = 3'd4, UP3 = 3'd5, DN3 = 3'd6, RSYNC = 3'd7;
   localparam logic [4:0] TOP = 5'(B_TOP), MID = 5'(B_MID), HI2 = 5'(B_UP2), LOW = 5'(B_LOW);

   logic       valid, up, dn, same, ok, kb, cd, stp, kick, kick_n;
   logic       e0, e1, e2;
   logic [4:0] n;
   logic [2:0] nx, ph_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level       <= '0;
         phase       <= IDLE;
         kick        <= 1'b0;
         step_up     <= 1'b0;
         step_down   <= 1'b0;
         kickback    <= 1'b0;
         cycle_done  <= 1'b0;
         cycle_count <= '0;
         err_pulse   <= 1'b0;
         err_flags   <= '0;
      end else begin
         level       <= valid ? n : level;
         phase       <= ph_n;
         kick        <= kick_n;
         step_up     <= stp && up;
         step_down   <= stp && dn;
         kickback    <= stp && kb;
         cycle_done  <= stp && cd;
         cycle_count <= cycle_count + CNT_W'(stp && cd && cycle_count != '1);
         err_pulse   <= e0 || e1 || e2;
         err_flags   <= err_flags | {e2, e1, e0};
      end
   end

   // ok/nx describe a single +1/-1 step from the current phase; bounds are on the new or old level
   always_comb begin
      valid = (led & (led + WIDTH'(1))) == '0;
      n = '0;
      for (int i = 0; i < WIDTH; i++) n = n + 5'(led[i]);
      up   = valid && n == level + 5'd1;
      dn   = valid && n + 5'd1 == level;
      same = valid && n == level;
      ok = 1'b0;
      nx = RSYNC;
      kb = 1'b0;
      cd = 1'b0;
      case (phase)
         IDLE: begin ok = up; nx = UP1; end
         UP1:  begin ok = up ? n <= TOP : level == TOP; nx = up ? UP1 : DN1; end
         DN1:  begin ok = dn ? n >= MID : level == MID; nx = dn ? DN1 : kick ? UP1 : UP2; kb = up && kick; end
         UP2:  begin ok = up ? n <= HI2 : level == HI2; nx = up ? UP2 : DN2; end
         DN2:  begin ok = dn ? n >= LOW : level == LOW; nx = dn ? DN2 : kick ? UP2 : UP3; kb = up && kick; end
         UP3:  begin ok = up ? n <= MID : level == MID; nx = up ? UP3 : DN3; end
         DN3:  begin ok = dn; nx = n == '0 ? IDLE : DN3; cd = dn && n == '0; end
         default: begin ok = 1'b0; nx = RSYNC; end
      endcase
      stp  = (up || dn) && ok;
      ph_n = !valid ? RSYNC : phase == RSYNC ? (n == '0 ? IDLE : RSYNC) : same ? phase : stp ? nx : RSYNC;
      kick_n = (ph_n == phase && kick) ||
               (valid && flick && ((ph_n == DN1 && n == MID) || (ph_n == DN2 && n == LOW)));
   end

   // a non-thermometer code masks any jump check; RESYNC only reports new invalid codes
   always_comb begin
      e0 = !valid;
      e1 = valid && phase != RSYNC && !same && !up && !dn;
      e2 = valid && phase != RSYNC && (up || dn) && !ok;
   end
endmodule

// File: tb/tb_bound_flasher_monitor.sv
// tb_bound_flasher_monitor: directed vectors pushed into a scoreboard queue; a monitor
// pops one expected output bundle per clock and compares it to the DUT.
module tb_bound_flasher_monitor;
   localparam logic [2:0] IDLE = 3'd0, UP1 = 3'd1, DN1 = 3'd2, UP2 = 3'd3,
                          DN2 = 3'd4, UP3 = 3'd5, DN3 = 3'd6, RS = 3'd7;

   logic        clk = 1'b0, rst = 1'b1, flick = 1'b0;
   logic [15:0] led = '0;
   logic [4:0]  level;
   logic [2:0]  phase, err_flags;
   logic        step_up, step_down, kickback, cycle_done, err_pulse;
   logic [1:0]  cycle_count;

   bound_flasher_monitor #(.CNT_W(2)) dut (
      .clk(clk), .rst(rst), .led(led), .flick(flick), .level(level), .phase(phase),
      .step_up(step_up), .step_down(step_down), .kickback(kickback), .cycle_done(cycle_done),
      .cycle_count(cycle_count), .err_pulse(err_pulse), .err_flags(err_flags)
   );

   always #5 clk = ~clk;

   logic [17:0] q[$];
   string       tq[$];
   logic [17:0] e;
   string       t;
   int          nvec = 0, nbad = 0, nstep = 0;
   logic [4:0]  elv = '0;
   logic [1:0]  ecnt = '0;
   logic [2:0]  eef = '0;
   wire  [17:0] act = {level, phase, step_up, step_down, kickback, cycle_done, cycle_count, err_pulse, err_flags};

   always @(posedge clk) begin
      #1;
      if (step_up || step_down) nstep++;
      if (q.size() > 0) begin
         e = q.pop_front();
         t = tq.pop_front();
         nvec++;
         if (act !== e) begin
            nbad++;
            $display("FAIL %s: got %b want %b (lvl,ph,su,sd,kb,cd,cnt,ep,ef)", t, act, e);
         end
      end
   end

   function automatic logic [15:0] th(input int n);
      logic [31:0] x;
      x = (32'd1 << n) - 32'd1;
      return x[15:0];
   endfunction

   task automatic push(input logic [15:0] l, input logic f, input logic [2:0] ph,
                       input logic [3:0] p, input logic ep, input string s);
      @(negedge clk);
      led = l;
      flick = f;
      q.push_back({elv, ph, p, ecnt, ep, eef});
      tq.push_back(s);
   endtask

   task automatic go(input int n, input logic [2:0] ph, input logic [3:0] p, input logic f, input string s);
      elv = 5'(n);
      if (p[0]) ecnt = (ecnt == 2'd3) ? 2'd3 : ecnt + 2'd1;
      push(th(n), f, ph, p, 1'b0, s);
   endtask

   task automatic full(input string s);
      for (int n = 1; n <= 16; n++) go(n, UP1, 4'b1000, 1'b0, s);
      for (int n = 15; n >= 6; n--) go(n, DN1, 4'b0100, 1'b0, s);
      for (int n = 7; n <= 11; n++) go(n, UP2, 4'b1000, 1'b0, s);
      for (int n = 10; n >= 1; n--) go(n, DN2, 4'b0100, 1'b0, s);
      for (int n = 2; n <= 6; n++) go(n, UP3, 4'b1000, 1'b0, s);
      for (int n = 5; n >= 1; n--) go(n, DN3, 4'b0100, 1'b0, s);
      go(0, IDLE, 4'b0101, 1'b0, s);
   endtask

   task automatic drain;
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset(input string s);
      drain;
      rst = 1'b1;
      led = '0;
      flick = 1'b0;
      #1;
      nvec++;
      if (act !== 18'd0) begin
         nbad++;
         $display("FAIL %s: got %b want all zero", s, act);
      end
      @(negedge clk);
      rst = 1'b0;
      elv = '0;
      ecnt = '0;
      eef = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1);
   end

   initial begin
      repeat (10) go(0, IDLE, 4'b0000, 1'b0, "reset");
      drain;
      @(negedge clk);
      rst = 1'b0;
      nstep = 0;
      full("cycle");
      drain;
      nvec++;
      if (nstep != 52) begin
         nbad++;
         $display("FAIL step_total: got %0d want 52", nstep);
      end
      for (int n = 1; n <= 16; n++) go(n, UP1, 4'b1000, 1'b0, "kick_up1");
      for (int n = 15; n >= 7; n--) go(n, DN1, 4'b0100, 1'b0, "kick_dn1");
      go(6, DN1, 4'b0100, 1'b1, "kick_dn1");
      go(6, DN1, 4'b0000, 1'b1, "hold_dn1");
      go(7, UP1, 4'b1010, 1'b0, "kickback1");
      for (int n = 8; n <= 16; n++) go(n, UP1, 4'b1000, 1'b0, "kick_up1b");
      for (int n = 15; n >= 6; n--) go(n, DN1, 4'b0100, 1'b0, "kick_dn1b");
      for (int n = 7; n <= 11; n++) go(n, UP2, 4'b1000, 1'b0, "no_kick_up2");
      for (int n = 10; n >= 2; n--) go(n, DN2, 4'b0100, 1'b0, "kick_dn2");
      go(1, DN2, 4'b0100, 1'b1, "kick_dn2");
      go(2, UP2, 4'b1010, 1'b0, "kickback2");
      for (int n = 3; n <= 11; n++) go(n, UP2, 4'b1000, 1'b0, "kick_up2b");
      for (int n = 10; n >= 1; n--) go(n, DN2, 4'b0100, 1'b0, "kick_dn2b");
      for (int n = 2; n <= 6; n++) go(n, UP3, 4'b1000, 1'b0, "kick_up3");
      for (int n = 5; n >= 1; n--) go(n, DN3, 4'b0100, 1'b0, "kick_dn3");
      go(0, IDLE, 4'b0101, 1'b0, "kick_done");
      for (int n = 1; n <= 4; n++) go(n, UP1, 4'b1000, 1'b0, "pre_bad");
      eef = 3'b001;
      push(16'h0005, 1'b0, RS, 4'b0000, 1'b1, "nonthermo");
      push(16'h0009, 1'b0, RS, 4'b0000, 1'b1, "nonthermo_rs");
      go(0, IDLE, 4'b0000, 1'b0, "resync_exit");
      for (int n = 1; n <= 3; n++) go(n, UP1, 4'b1000, 1'b0, "pre_jump");
      eef = 3'b011;
      elv = 5'd5;
      push(th(5), 1'b0, RS, 4'b0000, 1'b1, "jump");
      go(0, IDLE, 4'b0000, 1'b0, "jump_exit");
      for (int n = 1; n <= 9; n++) go(n, UP1, 4'b1000, 1'b0, "pre_rev");
      eef = 3'b111;
      elv = 5'd8;
      push(th(8), 1'b0, RS, 4'b0000, 1'b1, "reversal");
      go(0, IDLE, 4'b0000, 1'b0, "rev_exit");
      do_reset("rst_clear");
      repeat (5) full("saturate");
      for (int n = 1; n <= 16; n++) go(n, UP1, 4'b1000, 1'b0, "mid_up1");
      for (int n = 15; n >= 6; n--) go(n, DN1, 4'b0100, 1'b0, "mid_dn1");
      for (int n = 7; n <= 9; n++) go(n, UP2, 4'b1000, 1'b0, "mid_up2");
      do_reset("rst_mid_up2");
      go(0, IDLE, 4'b0000, 1'b0, "post_rst");
      go(1, UP1, 4'b1000, 1'b0, "post_rst_step");
      drain;
      nvec++;
      if (q.size() != 0) begin
         nbad++;
         $display("FAIL queue_empty: got %0d pending want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end
endmodule
